// File: rtl/avg_level_detector_if.sv
// Bundle for the averaged-sample stream into the level detector and its status outputs.
// master drives samples, thresholds and clear; slave is the detector.
interface avg_level_detector_if #(
  parameter int unsigned WL = 4,
  parameter int unsigned CW = 8
);
  logic          valid;
  logic [WL-1:0] din;
  logic [WL-1:0] hi_th;
  logic [WL-1:0] lo_th;
  logic          clr;
  logic          level;
  logic          rise;
  logic          fall;
  logic [CW-1:0] event_count;
  logic          cfg_err;
  logic [WL-1:0] peak_out;
  logic          peak_valid;

  modport master (
    output valid, din, hi_th, lo_th, clr,
    input  level, rise, fall, event_count, cfg_err, peak_out, peak_valid
  );

  modport slave (
    input  valid, din, hi_th, lo_th, clr,
    output level, rise, fall, event_count, cfg_err, peak_out, peak_valid
  );
endinterface

// File: rtl/avg_level_detector.sv
// Hysteresis level detector with N-sample debounce, rise/fall pulses and saturating rise count.
// Define AVG_LEVEL_DET_PEAK_EN to capture the peak of each completed high excursion.
module avg_level_detector #(
  parameter int unsigned WL = 4,
  parameter int unsigned N  = 2,
  parameter int unsigned CW = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  avg_level_detector_if.slave  bus
);
  localparam int unsigned     CntW     = $clog2(N + 1);
  localparam logic [CntW-1:0] CntLast  = CntW'(N - 1);
  localparam logic [CW-1:0]   CountMax = '1;

  typedef enum logic [1:0] {StLow, StArmH, StHigh, StArmL} state_e;

  state_e        state_q;
  logic [CntW-1:0] cnt_q;
  logic          rise_q, fall_q;
  logic [CW-1:0] count_q;
  logic          cfg_err, accept, qual_hi, qual_lo, go_high, go_low, level;

  assign cfg_err = bus.lo_th >= bus.hi_th;
  assign accept  = bus.valid && !cfg_err;
  assign qual_hi = bus.din >= bus.hi_th;
  assign qual_lo = bus.din <= bus.lo_th;
  assign level   = (state_q == StHigh) || (state_q == StArmL);

  // Level-change decode, shared by the FSM, the counter and the peak capture.
  always_comb begin
    go_high = 1'b0;
    go_low  = 1'b0;
    if (accept) begin
      unique case (state_q)
        StLow:   go_high = qual_hi && (N == 1);
        StArmH:  go_high = qual_hi && (cnt_q == CntLast);
        StHigh:  go_low  = qual_lo && (N == 1);
        StArmL:  go_low  = qual_lo && (cnt_q == CntLast);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StLow;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      count_q <= '0;
    end else begin
      rise_q <= go_high;
      fall_q <= go_low;
      if (accept) begin
        unique case (state_q)
          StLow: begin
            if (go_high) begin
              state_q <= StHigh;
            end else if (qual_hi) begin
              state_q <= StArmH;
              cnt_q   <= CntW'(1);
            end
          end
          StArmH: begin
            if (go_high) begin
              state_q <= StHigh;
              cnt_q   <= '0;
            end else if (qual_hi) begin
              cnt_q <= cnt_q + 1'b1;
            end else begin
              state_q <= StLow;
              cnt_q   <= '0;
            end
          end
          StHigh: begin
            if (go_low) begin
              state_q <= StLow;
            end else if (qual_lo) begin
              state_q <= StArmL;
              cnt_q   <= CntW'(1);
            end
          end
          StArmL: begin
            if (go_low) begin
              state_q <= StLow;
              cnt_q   <= '0;
            end else if (qual_lo) begin
              cnt_q <= cnt_q + 1'b1;
            end else begin
              state_q <= StHigh;
              cnt_q   <= '0;
            end
          end
          default: begin
            state_q <= StLow;
            cnt_q   <= '0;
          end
        endcase
      end
      // Clear takes priority over a coincident rise.
      if (bus.clr) begin
        count_q <= '0;
      end else if (go_high && (count_q != CountMax)) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign bus.level       = level;
  assign bus.rise        = rise_q;
  assign bus.fall        = fall_q;
  assign bus.event_count = count_q;
  assign bus.cfg_err     = cfg_err;

`ifdef AVG_LEVEL_DET_PEAK_EN
  logic [WL-1:0] peak_q, peak_out_q, peak_max;
  logic          peak_valid_q;

  assign peak_max = (bus.din > peak_q) ? bus.din : peak_q;

  // The falling sample itself is still part of the excursion, so it joins the max.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_q       <= '0;
      peak_out_q   <= '0;
      peak_valid_q <= 1'b0;
    end else begin
      peak_valid_q <= go_low;
      if (go_high) begin
        peak_q <= bus.din;
      end else if (bus.valid && level) begin
        peak_q <= peak_max;
      end
      if (go_low) begin
        peak_out_q <= peak_max;
      end
    end
  end

  assign bus.peak_out   = peak_out_q;
  assign bus.peak_valid = peak_valid_q;
`else
  assign bus.peak_out   = '0;
  assign bus.peak_valid = 1'b0;
`endif
endmodule

// File: tb/tb_avg_level_detector.sv
// Scoreboard bench for avg_level_detector (WL=4, N=2, CW=2); honours AVG_LEVEL_DET_PEAK_EN.
module tb_avg_level_detector;
  localparam int unsigned WL = 4;
  localparam int unsigned N  = 2;
  localparam int unsigned CW = 2;
  localparam int CountMax    = (1 << CW) - 1;

  typedef struct {
    int level;
    int rise;
    int fall;
    int count;
    int peak_out;
    int peak_valid;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   hi;
  int   lo;
  exp_t sb_q[$];
  exp_t mon_e;

  // Reference model state
  int m_level, m_run, m_count, m_peak, m_peak_out;

  avg_level_detector_if #(.WL(WL), .CW(CW)) bus ();

  avg_level_detector #(.WL(WL), .N(N), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_level    = 0;
    m_run      = 0;
    m_count    = 0;
    m_peak     = 0;
    m_peak_out = 0;
  endtask

  // Drive one cycle; the model predicts the outputs visible after the next rising edge.
  task automatic step(input bit v, input int d, input bit c);
    exp_t e;
    int   was_high;
    @(negedge clk);
    bus.valid = v;
    bus.din   = WL'(d);
    bus.clr   = c;
    bus.hi_th = WL'(hi);
    bus.lo_th = WL'(lo);
    e.rise = 0;
    e.fall = 0;
    e.peak_valid = 0;
    was_high = m_level;
    if (v && !(lo >= hi)) begin
      if (!m_level) begin
        if (d >= hi) begin
          m_run++;
          if (m_run >= N) begin
            m_level = 1;
            m_run   = 0;
            e.rise  = 1;
          end
        end else m_run = 0;
      end else begin
        if (d <= lo) begin
          m_run++;
          if (m_run >= N) begin
            m_level = 0;
            m_run   = 0;
            e.fall  = 1;
          end
        end else m_run = 0;
      end
    end
`ifdef AVG_LEVEL_DET_PEAK_EN
    if (v) begin
      if (e.rise) m_peak = d;
      else if (was_high && d > m_peak) m_peak = d;
    end
    if (e.fall) begin
      m_peak_out   = m_peak;
      e.peak_valid = 1;
    end
`endif
    if (c) m_count = 0;
    else if (e.rise && m_count < CountMax) m_count++;
    e.level    = m_level;
    e.count    = m_count;
    e.peak_out = m_peak_out;
    sb_q.push_back(e);
    @(posedge clk);
    #2;
    bus.valid = 1'b0;
    bus.clr   = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      check_eq("level", int'(bus.level), mon_e.level);
      check_eq("rise", int'(bus.rise), mon_e.rise);
      check_eq("fall", int'(bus.fall), mon_e.fall);
      check_eq("event_count", int'(bus.event_count), mon_e.count);
      check_eq("peak_out", int'(bus.peak_out), mon_e.peak_out);
      check_eq("peak_valid", int'(bus.peak_valid), mon_e.peak_valid);
    end
  end

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_level"}, int'(bus.level), 0);
    check_eq({tag, "_rise"}, int'(bus.rise), 0);
    check_eq({tag, "_fall"}, int'(bus.fall), 0);
    check_eq({tag, "_count"}, int'(bus.event_count), 0);
    check_eq({tag, "_peak_out"}, int'(bus.peak_out), 0);
    check_eq({tag, "_peak_valid"}, int'(bus.peak_valid), 0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    hi = 10;
    lo = 5;
    model_reset();
    rst_n     = 1'b0;
    bus.valid = 1'b0;
    bus.din   = '0;
    bus.clr   = 1'b0;
    bus.hi_th = WL'(hi);
    bus.lo_th = WL'(lo);
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    check_eq("cfg_err_ok", int'(bus.cfg_err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic rise, aborted ARM_L, fall
    step(1, 3, 0); step(1, 11, 0); step(1, 12, 0);
    check_eq("rise_after_12", int'(bus.rise), 1);
    check_eq("count_1", int'(bus.event_count), 1);
    step(1, 9, 0); step(1, 4, 0); step(1, 6, 0);
    check_eq("armL_aborted_level", int'(bus.level), 1);
    step(1, 4, 0); step(1, 2, 0);
    check_eq("fall_after_2", int'(bus.fall), 1);
    check_eq("level_low", int'(bus.level), 0);

    // Debounce restart, then idle cycles inside the debounce
    step(1, 11, 0); step(1, 3, 0); step(1, 11, 0);
    check_eq("no_rise_restart", int'(bus.level), 0);
    step(0, 0, 0); step(0, 15, 0);
    check_eq("idle_holds", int'(bus.level), 0);
    step(1, 12, 0);
    check_eq("rise_after_idle", int'(bus.rise), 1);
    step(1, 4, 0); step(1, 4, 0);

    // Threshold misconfiguration blocks state changes
    hi = 5;
    step(0, 0, 0);
    check_eq("cfg_err_set", int'(bus.cfg_err), 1);
    step(1, 15, 0); step(1, 15, 0); step(1, 15, 0);
    check_eq("cfg_err_level", int'(bus.level), 0);
    hi = 10;
    step(1, 15, 0);
    check_eq("cfg_err_clear", int'(bus.cfg_err), 0);
    step(1, 15, 0);
    check_eq("rise_after_restore", int'(bus.rise), 1);
    step(1, 4, 0); step(1, 4, 0);

    // Two more excursions: five total, count saturates at 3
    for (int i = 0; i < 2; i++) begin
      step(1, 11, 0); step(1, 11, 0); step(1, 4, 0); step(1, 4, 0);
    end
    check_eq("count_saturated", int'(bus.event_count), CountMax);
    step(1, 11, 0); step(1, 11, 1);
    check_eq("clr_beats_rise", int'(bus.event_count), 0);
    check_eq("rise_with_clr", int'(bus.rise), 1);
    step(1, 4, 0); step(1, 4, 0);

    // Peak capture across an excursion including ARM_L samples
    step(1, 11, 0); step(1, 12, 0); step(1, 14, 0); step(1, 9, 0);
    step(1, 13, 0); step(1, 4, 0); step(1, 3, 0);
    check_eq("peak_fall", int'(bus.fall), 1);
`ifdef AVG_LEVEL_DET_PEAK_EN
    check_eq("peak_out_14", int'(bus.peak_out), 14);
    check_eq("peak_valid_pulse", int'(bus.peak_valid), 1);
`else
    check_eq("peak_out_off", int'(bus.peak_out), 0);
    check_eq("peak_valid_off", int'(bus.peak_valid), 0);
`endif

    // Asynchronous reset while debouncing a fall
    step(1, 11, 0); step(1, 11, 0); step(1, 4, 0);
    check_eq("pre_reset_level", int'(bus.level), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_no_fall", int'(bus.fall), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 11, 0); step(1, 11, 0);
    check_eq("post_reset_rise", int'(bus.rise), 1);
    check_eq("post_reset_count", int'(bus.event_count), 1);

    repeat (3) @(posedge clk);
    #3;
    check_eq("scoreboard_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/avg_level_detector.md
# avg_level_detector

Hysteresis level detector that consumes the averaged sample stream produced by the moving-average stage (`avg` plus a one-cycle sample strobe). It applies high and low thresholds with an N-sample debounce, emits rise/fall pulses and a saturating event count, and optionally captures the peak value of each high excursion. It sits directly downstream of the moving-average filter and feeds control and status logic.

## Interface
- `WL`, 4: sample width in bits; must match the upstream average width.
- `N`, 2: consecutive qualifying samples needed to change level; must be ≥1.
- `CW`, 8: event counter width.
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RST_N` in 1: reset, asynchronous assert, active-low.
- `valid` in 1: sample strobe; `din` is accepted on any rising edge where `valid`=1.
- `din` in WL: unsigned averaged sample.
- `hi_th` in WL: unsigned rise threshold; qualifies when `din` ≥ `hi_th`.
- `lo_th` in WL: unsigned fall threshold; qualifies when `din` ≤ `lo_th`.
- `clr` in 1: synchronous clear of `event_count`.
- `level` out 1: registered detector level.
- `rise` out 1: one-cycle pulse when the level goes low→high.
- `fall` out 1: one-cycle pulse when the level goes high→low.
- `event_count` out CW: number of rises, saturating.
- `cfg_err` out 1: combinational; 1 when `lo_th` ≥ `hi_th`.
- `peak_out` out WL: peak of the last completed high excursion.
- `peak_valid` out 1: one-cycle pulse when `peak_out` updates.

## Operation
- FSM states: LOW, ARM_H, HIGH, ARM_L.
- `level` is 1 in HIGH and ARM_L, and 0 in LOW and ARM_H.
- Debounce counter `cnt` has width `$clog2(N+1)`.
- **LOW:** an accepted sample with `din` ≥ `hi_th`:
  - if N=1, go to HIGH and pulse `rise`;
  - otherwise go to ARM_H with `cnt`=1.
- **ARM_H:** on an accepted sample:
  - qualifying: `cnt`+1. When it reaches N, go to HIGH, pulse `rise`, and set `cnt`=0.
  - non-qualifying: go to LOW, `cnt`=0.
- **HIGH / ARM_L:** mirror of LOW / ARM_H, using `din` ≤ `lo_th`, returning to LOW and pulsing `fall`.
- Cycles with `valid`=0 hold state and `cnt`; debounce counts samples, not cycles.
- When `cfg_err`=1, accepted samples cause no state change and `cnt` holds.
- Thresholds are evaluated only on accepted samples; changing them mid-debounce is legal.
- `event_count` increments on each `rise` and saturates at 2^CW−1.
- `clr` zeroes `event_count`. If `clr` and a rise occur together, `clr` wins and the count is 0.
- All comparisons are unsigned and full WL width; no arithmetic on `din`.

## Timing
- Latency: `rise`, `fall`, `level`, `event_count` and `peak_*` update at the same edge that accepts the qualifying sample, visible the following cycle.
- `rise` and `fall` are high for exactly one cycle and never together.
- No backpressure: every `valid` is accepted. Back-to-back `valid` each cycle is supported.
- Reset values:
  - FSM in LOW, `cnt`=0;
  - `level`, `rise`, `fall`, `peak_valid` = 0;
  - `event_count`=0, `peak_out`=0.
- Reset mid-excursion drops to LOW with no `fall` pulse and no `peak_valid` pulse.
- An internal peak register is kept under `AVG_LEVEL_DET_PEAK_EN` (see Configuration).

## Configuration
- Macro: `AVG_LEVEL_DET_PEAK_EN`.
- **Defined:**
  - The internal peak register loads `din` on the sample that causes `rise`.
  - While `level`=1, it updates to max(peak, `din`) on every accepted sample, including ARM_L samples.
  - On `fall`, `peak_out` takes the peak value and `peak_valid` pulses with `fall`.
  - Both the peak register and `peak_out` reset to 0.
- **Undefined:** `peak_out`=0 and `peak_valid`=0 constantly; the ports remain present.

## Test plan
- WL=4, N=2, hi=10, lo=5.
  - Samples 3, 11, 12 → `rise` after the 12, `level`=1, `event_count`=1.
  - Then 9, 4, 6 → no `fall`; ARM_L is aborted by the 6.
  - Then 4, 2 → `fall` after the 2, `level`=0.
- Samples 11, 3, 11 → no `rise`; debounce restarts. Idle cycles with `valid`=0 between 11 and 12 still produce `rise` after the 12.
- Set hi=5, lo=5 → `cfg_err`=1. Samples 15, 15, 15 → `level` stays 0. Restoring hi=10 with two more samples of 15 → `rise`.
- CW=2: five complete excursions → `event_count`=3 (saturated). `clr` pulsed on the cycle of the 6th rise → `event_count`=0.
- With `AVG_LEVEL_DET_PEAK_EN`:
  - Samples 11, 12, 14, 9, 13, 4, 3 → `peak_out`=14 with `peak_valid` coincident with `fall`.
  - Without the macro → `peak_out`=0, `peak_valid`=0.
- Assert `RST_N`=0 asynchronously in HIGH mid-debounce → all outputs reset immediately, no `fall` pulse. Release, then samples 11, 11 → `rise`, `event_count`=1.
